// File: rtl/data_mem_ctrl.sv
// Load/store memory controller: valid/ready request, one-cycle response pulse,
// byte-addressable synchronous RAM plus a 16-byte MMIO window (GPIO, cycle counter, edge capture).
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
  parameter int unsigned N_IN        = 19,
  parameter int unsigned N_OUT       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned WW        = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESP} state_t;

  state_t             r_state, w_next;
  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [31:0]        r_ram_q;
  logic               r_we, r_uns, r_err, r_io;
  logic [1:0]         r_size, r_lane, r_off;
  logic [AW-1:0]      r_widx;
  logic [WW-1:0]      r_wdata;
  logic [31:0]        r_cycle;
  logic [N_IN-1:0]    r_s1, r_s2, r_hist, r_edge;
  logic [N_OUT-1:0]   r_gpio_out;

  logic               w_accept, w_in_ram, w_in_io, w_misal, w_err, w_ram_wr, w_mmio_wr;
  logic [3:0]         w_be;
  logic [31:0]        w_wrep, w_load;
  logic [AW-1:0]      w_widx;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [N_IN-1:0]    w_clr;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_in_ram = {1'b0, req_addr} < RAM_BYTES;
  assign w_in_io  = req_addr[31:4] == IO_BASE[31:4];
  assign w_misal  = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_err    = (req_size == 2'b11) || w_misal || !(w_in_ram || w_in_io) ||
                    (w_in_io && (req_size != 2'b10));
  assign w_widx   = req_addr[AW+1:2];
  assign w_ram_wr = w_accept && req_we && w_in_ram && !w_err;

  always_comb begin
    w_be   = 4'b1111;
    w_wrep = req_wdata;
    case (req_size)
      2'b00: begin
        w_be   = 4'b0001 << req_addr[1:0];
        w_wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM has no reset: contents survive rst, and the read port only updates in LOAD.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wrep[8*i +: 8];
      end
    end
    if (r_state == S_LOAD) r_ram_q <= r_mem[r_widx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_io    <= 1'b0;
      r_size  <= '0;
      r_lane  <= '0;
      r_off   <= '0;
      r_widx  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_uns   <= req_unsigned;
      r_err   <= w_err;
      r_io    <= w_in_io;
      r_size  <= req_size;
      r_lane  <= req_addr[1:0];
      r_off   <= req_addr[3:2];
      r_widx  <= w_widx;
      r_wdata <= req_wdata[WW-1:0];
    end
  end

  assign w_mmio_wr = (r_state == S_RESP) && r_we && r_io && !r_err;
  assign w_clr     = (w_mmio_wr && (r_off == 2'd3)) ? r_wdata[N_IN-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle    <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_hist     <= '0;
      r_edge     <= '0;
      r_gpio_out <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_s1    <= gpio_in;
      r_s2    <= r_s1;
      r_hist  <= r_s2;
      // A rising edge in the same cycle as a W1C clear keeps the bit set.
      r_edge  <= (r_edge & ~w_clr) | (r_s2 & ~r_hist);
      if (w_mmio_wr && (r_off == 2'd0)) r_gpio_out <= r_wdata[N_OUT-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = (!req_we && w_in_ram && !w_err) ? S_LOAD : S_RESP;
      S_LOAD: w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = 8'(r_ram_q >> {r_lane, 3'b000});
    w_half = r_lane[1] ? r_ram_q[31:16] : r_ram_q[15:0];
    case (r_size)
      2'b00:   w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = r_ram_q;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    resp_err   = (r_state == S_RESP) && r_err;
    resp_rdata = '0;
    if ((r_state == S_RESP) && !r_err && !r_we) begin
      if (r_io) begin
        case (r_off)
          2'd0:    resp_rdata = 32'(r_gpio_out);
          2'd1:    resp_rdata = 32'(r_s2);
          2'd2:    resp_rdata = r_cycle;
          default: resp_rdata = 32'(r_edge);
        endcase
      end else begin
        resp_rdata = w_load;
      end
    end
  end

  assign gpio_out = r_gpio_out;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised load/store memory controller for the RISC-V core. It replaces the fixed-latency combinational memory path with a valid/ready request and response handshake. It contains a byte-addressable synchronous RAM with byte/half/word stores and sign/zero-extended loads, plus an MMIO window for GPIO output, synchronised GPIO input with rising-edge capture, and a free-running cycle counter. Misaligned and unmapped accesses are reported through an error response instead of corrupting memory.

## Interface
- DEPTH_WORDS, 4096: RAM depth in 32-bit words; power of two.
- IO_BASE, 32'hFFFF_0000: base of 16-byte MMIO window; 16-byte aligned.
- N_IN, 19: GPIO input width (switches and buttons), 1..32.
- N_OUT, 16: GPIO output width (LEDs), 1..32.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and raises an error.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; access was misaligned, unmapped or illegal.
- gpio_in  in  N_IN  asynchronous external inputs.
- gpio_out  out  N_OUT  registered outputs.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - LOAD: RAM read in flight.
  - RESP: drive the response.
- Transitions:
  - IDLE->LOAD on an accepted RAM load.
  - IDLE->RESP on any other accepted request.
  - LOAD->RESP unconditionally.
  - RESP->IDLE unconditionally.
- A request is accepted when req_valid and req_ready are both high. All request fields are registered at acceptance.
- Error checks, all raising resp_err:
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
  - req_size 11.
  - RAM region is addr < 4*DEPTH_WORDS. An address in neither the RAM region nor the MMIO window is an error.
  - MMIO access with size other than word.
- On error: no state change, no write, resp_rdata=0.
- RAM stores: byte-lane write enables are derived from size and addr[1:0]. Data is replicated into the selected lanes, and unselected bytes are preserved. The write commits on the acceptance edge.
- RAM loads: the selected lane is shifted down to bit 0, then extended per req_unsigned. Word loads ignore req_unsigned.
- MMIO map (offset from IO_BASE):
  - 0x0: GPIO_OUT, RW. Writes take wdata[N_OUT-1:0]; reads zero-extend.
  - 0x4: GPIO_IN, RO. Value after a 2-flop synchroniser, zero-extended.
  - 0x8: CYCLE, RO. 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF->0.
  - 0xC: EDGE, W1C. Bit i sets on a rising edge of synchronised gpio_in[i]. Writing 1 clears the bit; writing 0 leaves it unchanged.
- Writes to RO registers are ignored without error.
- EDGE set and clear in the same cycle: set wins.
- RAM contents are not reset or initialised.

## Timing
- Store, MMIO, or error request accepted at edge N: resp_valid high in cycle N+1.
- RAM load accepted at edge N: RAM output at edge N+1, resp_valid high in cycle N+2.
- Throughput: one request every 2 cycles for stores/MMIO, every 3 cycles for RAM loads.
- req_ready is low in LOAD and RESP. There is no response backpressure: the consumer must take resp_* in the resp_valid cycle.
- GPIO_OUT and EDGE-clear writes are visible at the outputs at edge N+1.
- CYCLE read returns the counter value registered at the acceptance edge.
- gpio_in-to-GPIO_IN read latency is 2 cycles from the input change. EDGE sets 3 cycles after the input edge: 2 sync flops plus 1 history flop.
- Reset values (asynchronous on rst):
  - State IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - gpio_out=0, CYCLE=0, EDGE=0, sync/history flops=0.
- Reset mid-operation: an in-flight load or response is dropped and no resp_valid is produced. A RAM store already committed stays committed.

## Test plan
- Byte/half/word store-load: store word 0x8081_82FF at 0x10, then:
  - lb 0x10 -> 0xFFFF_FFFF
  - lbu 0x13 -> 0x0000_0080
  - lh 0x12 -> 0xFFFF_8081
  - lw 0x10 -> 0x8081_82FF
  - each load resp 2 cycles after acceptance.
- Lane preservation: sb 0xAA to 0x11 over 0x1122_3344 -> lw 0x10 returns 0x1122_AA44.
- Errors, each giving resp_err=1, rdata=0, and RAM unchanged:
  - sw to 0x12
  - lh at 0x13
  - lw at 4*DEPTH_WORDS
  - sb to IO_BASE
  - req_size=11
- GPIO:
  - sw 0x1_A5A5 to IO_BASE -> gpio_out=0xA5A5 next cycle.
  - gpio_in bit0 0->1 -> EDGE reads 0x1 after 3 cycles.
  - Writing 1 to EDGE clears it; a rising edge coincident with the clear keeps the bit set.
- Counter: two CYCLE reads accepted k cycles apart differ by k. Force the counter to 0xFFFF_FFFF and confirm the wrap to 0.
- Handshake/reset:
  - Back-to-back req_valid: req_ready low in LOAD/RESP, no request lost or duplicated.
  - Assert rst in the LOAD cycle: no resp_valid, all outputs at reset values, req_ready=1 after release.
